// File: rtl/throw_charge_ctl_if.sv
// Purpose: groups the turn/button/flight handshake and meter outputs of throw_charge_ctl.
// Latency: n/a (signal bundle only).
// Backpressure: throw_done is a level held by the downstream throw controller; enable is held until it rises.
//
// Signals:
//   turn_active  - this player's turn (master -> slave)
//   fire_btn     - throw button level, already synchronised (master -> slave)
//   throw_done   - end-of-flight level from downstream (master -> slave)
//   enable       - start/hold request to downstream (slave -> master)
//   throw_force  - live meter while charging, latched during flight (slave -> master)
//   wind_force   - wind for the current turn, 0..100 (slave -> master)
//   charging     - meter active (slave -> master)
//   turn_end     - one-cycle pulse when the throw sequence completes (slave -> master)
interface throw_charge_ctl_if;
    logic       turn_active;
    logic       fire_btn;
    logic       throw_done;
    logic       enable;
    logic [9:0] throw_force;
    logic [6:0] wind_force;
    logic       charging;
    logic       turn_end;

    // Game/turn logic side: drives the requests, observes the meter.
    modport master (
        output turn_active,
        output fire_btn,
        output throw_done,
        input  enable,
        input  throw_force,
        input  wind_force,
        input  charging,
        input  turn_end
    );

    // Charge controller side.
    modport slave (
        input  turn_active,
        input  fire_btn,
        input  throw_done,
        output enable,
        output throw_force,
        output wind_force,
        output charging,
        output turn_end
    );
endinterface

// File: rtl/throw_charge_ctl.sv
// Purpose: button-driven ping-pong force meter that launches a throw and waits out its flight.
// Latency: all outputs registered; a press/release/throw_done is reflected one clk after it is sampled.
// Backpressure: enable is held for the whole flight; the block waits in DONE_WAIT while throw_done stays high.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - throw_charge_ctl_if.slave (turn_active, fire_btn, throw_done in;
//          enable, throw_force[9:0], wind_force[6:0], charging, turn_end out)
module throw_charge_ctl #(
    parameter int TICK_CYCLES = 650000,  // clk cycles per charge step
    parameter int FORCE_STEP  = 2,       // force change per step
    parameter int FORCE_MAX   = 100,     // force ceiling
    parameter int WIND_CALM   = 50       // wind value meaning no wind
) (
    input  logic                     clk,
    input  logic                     rst,
    throw_charge_ctl_if.slave        bus
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [9:0]    FMAX      = 10'(FORCE_MAX);
    localparam logic [9:0]    FSTEP     = 10'(FORCE_STEP);
    localparam logic [6:0]    WCALM     = 7'(WIND_CALM);
    localparam logic [15:0]   LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_CHARGE    = 2'd1,
        S_FLIGHT    = 2'd2,
        S_DONE_WAIT = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t        r_state;
    logic          r_fire_q;
    logic [TW-1:0] r_tick;
    logic          r_dir_up;
    logic [9:0]    r_force;
    logic [6:0]    r_wind;
    logic [15:0]   r_lfsr;
    logic          r_enable;
    logic          r_charging;
    logic          r_turn_end;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    state_t        w_state_nxt;
    logic [TW-1:0] w_tick_nxt;
    logic          w_dir_up_nxt;
    logic [9:0]    w_force_nxt;
    logic [6:0]    w_wind_nxt;
    logic          w_enable_nxt;
    logic          w_charging_nxt;
    logic          w_turn_end_nxt;

    logic          w_press;
    logic          w_release;
    logic          w_tick_wrap;
    logic [10:0]   w_force_up;
    logic [9:0]    w_force_step;
    logic          w_dir_up_step;
    logic          w_lfsr_fb;
    logic [6:0]    w_wind_raw;
    logic [6:0]    w_wind_new;

    // A press needs a fresh rising edge, so a button already held when the
    // turn starts never begins a charge.
    assign w_press     = bus.fire_btn & ~r_fire_q;
    assign w_release   = ~bus.fire_btn;
    assign w_tick_wrap = (r_tick == TICK_LAST);

    // Ping-pong step, saturating at both ends; the direction flips on the
    // step that lands on an end so the next step heads back.
    assign w_force_up = {1'b0, r_force} + {1'b0, FSTEP};

    always_comb begin
        w_force_step  = r_force;
        w_dir_up_step = r_dir_up;
        if (r_dir_up) begin
            if (w_force_up >= {1'b0, FMAX}) begin
                w_force_step  = FMAX;
                w_dir_up_step = 1'b0;
            end else begin
                w_force_step  = w_force_up[9:0];
            end
        end else begin
            if (r_force <= FSTEP) begin
                w_force_step  = 10'd0;
                w_dir_up_step = 1'b1;
            end else begin
                w_force_step  = r_force - FSTEP;
            end
        end
    end

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
    // Non-zero seed and maximal-length taps keep it off the all-zero state.
    assign w_lfsr_fb  = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    // Fold 101..127 down into 74..100 so every draw is a legal wind value.
    assign w_wind_raw = r_lfsr[6:0];
    assign w_wind_new = (w_wind_raw <= 7'd100) ? w_wind_raw : (w_wind_raw - 7'd27);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_press && bus.turn_active) begin
                    w_state_nxt = S_CHARGE;
                end
            end
            S_CHARGE: begin
                // Release takes priority over both a tick and a lost turn.
                if (w_release) begin
                    w_state_nxt = S_FLIGHT;
                end else if (!bus.turn_active) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FLIGHT: begin
                if (bus.throw_done) begin
                    w_state_nxt = S_DONE_WAIT;
                end
            end
            S_DONE_WAIT: begin
                if (!bus.throw_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / datapath next values (registered below)
    // ------------------------------------------------------------------
    always_comb begin
        w_tick_nxt     = r_tick;
        w_dir_up_nxt   = r_dir_up;
        w_force_nxt    = r_force;
        w_wind_nxt     = r_wind;
        w_turn_end_nxt = 1'b0;
        // Enable and charging follow the state being entered, so both are
        // valid on the same cycle the new state becomes visible.
        w_enable_nxt   = (w_state_nxt == S_FLIGHT);
        w_charging_nxt = (w_state_nxt == S_CHARGE);

        case (r_state)
            S_IDLE: begin
                w_force_nxt = 10'd0;
                if (w_press && bus.turn_active) begin
                    w_tick_nxt   = '0;
                    w_dir_up_nxt = 1'b1;
                end
            end
            S_CHARGE: begin
                if (w_release) begin
                    // Latch the un-stepped value even if a tick lands here.
                    w_force_nxt = r_force;
                end else if (!bus.turn_active) begin
                    w_force_nxt = 10'd0;
                end else if (w_tick_wrap) begin
                    w_tick_nxt   = '0;
                    w_force_nxt  = w_force_step;
                    w_dir_up_nxt = w_dir_up_step;
                end else begin
                    w_tick_nxt = r_tick + 1'b1;
                end
            end
            S_FLIGHT: begin
                // Force and wind hold; button and turn are ignored in flight.
            end
            S_DONE_WAIT: begin
                if (!bus.throw_done) begin
                    w_turn_end_nxt = 1'b1;
                    w_force_nxt    = 10'd0;
                    w_wind_nxt     = w_wind_new;
                end
            end
            default: begin
                w_force_nxt = 10'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath / output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fire_q   <= 1'b0;
            r_tick     <= '0;
            r_dir_up   <= 1'b1;
            r_force    <= 10'd0;
            r_wind     <= WCALM;
            r_lfsr     <= LFSR_SEED;
            r_enable   <= 1'b0;
            r_charging <= 1'b0;
            r_turn_end <= 1'b0;
        end else begin
            r_fire_q   <= bus.fire_btn;
            r_tick     <= w_tick_nxt;
            r_dir_up   <= w_dir_up_nxt;
            r_force    <= w_force_nxt;
            r_wind     <= w_wind_nxt;
            r_lfsr     <= {w_lfsr_fb, r_lfsr[15:1]};
            r_enable   <= w_enable_nxt;
            r_charging <= w_charging_nxt;
            r_turn_end <= w_turn_end_nxt;
        end
    end

    assign bus.enable      = r_enable;
    assign bus.throw_force = r_force;
    assign bus.wind_force  = r_wind;
    assign bus.charging    = r_charging;
    assign bus.turn_end    = r_turn_end;

endmodule

// File: tb/tb_throw_charge_ctl.sv
// Purpose: directed self-checking bench for throw_charge_ctl with TICK_CYCLES=4.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: throw_done is driven by the bench as the downstream flight controller.
module tb_throw_charge_ctl;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    // Reference wind source: the LFSR as described for the block.
    logic [15:0] m_lfsr;
    logic [15:0] m_lfsr_prev;

    throw_charge_ctl_if u_if ();

    throw_charge_ctl #(
        .TICK_CYCLES (4),
        .FORCE_STEP  (2),
        .FORCE_MAX   (100),
        .WIND_CALM   (50)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        m_lfsr_prev <= m_lfsr;
        if (rst) begin
            m_lfsr <= 16'hACE1;
        end else begin
            m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_wind(input logic [15:0] s);
        int v;
        v = int'(s[6:0]);
        return (v <= 100) ? v : (v - 27);
    endfunction

    // Finish a flight: throw_done high for n_done cycles, then low; checks
    // the enable drop, the single turn_end pulse and the new wind value.
    task automatic finish_flight(input string tag, input int n_done, input int held_force);
        u_if.throw_done = 1'b1;
        step();
        chk({tag, "_enable_drop"}, int'(u_if.enable), 0);
        repeat (n_done - 1) step();
        chk({tag, "_wait_no_end"}, int'(u_if.turn_end), 0);
        chk({tag, "_wait_force"}, int'(u_if.throw_force), held_force);
        u_if.throw_done = 1'b0;
        step();
        chk({tag, "_turn_end"}, int'(u_if.turn_end), 1);
        chk({tag, "_force_clr"}, int'(u_if.throw_force), 0);
        chk({tag, "_wind"}, int'(u_if.wind_force), exp_wind(m_lfsr_prev));
        chk({tag, "_wind_range"}, int'(u_if.wind_force <= 7'd100), 1);
        step();
        chk({tag, "_turn_end_1cyc"}, int'(u_if.turn_end), 0);
        chk({tag, "_idle_enable"}, int'(u_if.enable), 0);
    endtask

    initial begin
        int fmax;
        int fmin;
        int wind_now;

        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        u_if.turn_active = 1'b0;
        u_if.fire_btn    = 1'b0;
        u_if.throw_done  = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_enable",   int'(u_if.enable), 0);
        chk("rst_charging", int'(u_if.charging), 0);
        chk("rst_turn_end", int'(u_if.turn_end), 0);
        chk("rst_force",    int'(u_if.throw_force), 0);
        chk("rst_wind",     int'(u_if.wind_force), 50);
        rst = 1'b0;
        step();

        // Button held before the turn starts: no charge
        u_if.fire_btn = 1'b1;
        step();
        step();
        u_if.turn_active = 1'b1;
        repeat (3) step();
        chk("held_no_charge", int'(u_if.charging), 0);
        chk("held_no_enable", int'(u_if.enable), 0);
        u_if.fire_btn = 1'b0;
        step();

        // Basic throw: press, 20 held cycles (5 ticks), release -> 10
        u_if.fire_btn = 1'b1;
        step();
        chk("basic_charging", int'(u_if.charging), 1);
        chk("basic_force0",   int'(u_if.throw_force), 0);
        repeat (20) step();
        chk("basic_force20", int'(u_if.throw_force), 10);
        u_if.fire_btn = 1'b0;
        step();
        chk("basic_enable",   int'(u_if.enable), 1);
        chk("basic_latched",  int'(u_if.throw_force), 10);
        chk("basic_chg_off",  int'(u_if.charging), 0);

        // Flight ignores button and turn
        u_if.fire_btn    = 1'b1;
        u_if.turn_active = 1'b0;
        repeat (3) step();
        chk("flight_enable", int'(u_if.enable), 1);
        chk("flight_force",  int'(u_if.throw_force), 10);
        chk("flight_wind",   int'(u_if.wind_force), 50);
        u_if.fire_btn    = 1'b0;
        u_if.turn_active = 1'b1;
        step();

        // Handshake: throw_done high 3 cycles then low
        finish_flight("hs", 3, 10);
        wind_now = int'(u_if.wind_force);

        // Ping-pong over 55 ticks
        u_if.fire_btn = 1'b1;
        step();
        fmax = 0;
        fmin = 1000;
        for (int i = 1; i <= 220; i++) begin
            step();
            if (int'(u_if.throw_force) > fmax) fmax = int'(u_if.throw_force);
            if (int'(u_if.throw_force) < fmin) fmin = int'(u_if.throw_force);
            if (i == 200) chk("pp_tick50", int'(u_if.throw_force), 100);
            if (i == 204) chk("pp_tick51", int'(u_if.throw_force), 98);
            if (i == 220) chk("pp_tick55", int'(u_if.throw_force), 90);
        end
        chk("pp_max", fmax, 100);
        chk("pp_min", fmin, 0);
        chk("pp_wind_stable", int'(u_if.wind_force), wind_now);
        u_if.fire_btn = 1'b0;
        step();
        chk("pp_latched", int'(u_if.throw_force), 90);
        chk("pp_enable",  int'(u_if.enable), 1);
        finish_flight("pp", 1, 90);

        // Release on a tick cycle: pre-step value latched
        u_if.fire_btn = 1'b1;
        step();
        repeat (7) step();
        chk("tick_rel_pre", int'(u_if.throw_force), 2);
        u_if.fire_btn = 1'b0;
        step();
        chk("tick_rel_latched", int'(u_if.throw_force), 2);
        chk("tick_rel_enable",  int'(u_if.enable), 1);
        finish_flight("tr", 2, 2);

        // Turn lost mid-charge
        u_if.fire_btn = 1'b1;
        step();
        repeat (5) step();
        chk("drop_pre", int'(u_if.throw_force), 2);
        u_if.turn_active = 1'b0;
        step();
        chk("drop_charging", int'(u_if.charging), 0);
        chk("drop_force",    int'(u_if.throw_force), 0);
        chk("drop_enable",   int'(u_if.enable), 0);
        step();
        chk("drop_enable2",  int'(u_if.enable), 0);
        u_if.fire_btn    = 1'b0;
        u_if.turn_active = 1'b1;
        step();

        // Reset in flight
        u_if.fire_btn = 1'b1;
        step();
        repeat (4) step();
        u_if.fire_btn = 1'b0;
        step();
        chk("rf_pre_enable", int'(u_if.enable), 1);
        rst = 1'b1;
        step();
        chk("rf_enable",   int'(u_if.enable), 0);
        chk("rf_wind",     int'(u_if.wind_force), 50);
        chk("rf_force",    int'(u_if.throw_force), 0);
        chk("rf_turn_end", int'(u_if.turn_end), 0);
        chk("rf_charging", int'(u_if.charging), 0);
        rst = 1'b0;
        step();
        chk("rf_after_turn_end", int'(u_if.turn_end), 0);
        chk("rf_after_enable",   int'(u_if.enable), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
